// File: rtl/mem_pkg.sv
// mem_pkg: access codes, FSM/size types and lane helpers for the MEM-stage load/store unit.
package mem_pkg;

    localparam int XLEN  = 32;
    localparam int BE_W  = XLEN / 8;
    localparam int CNT_W = 8;

    localparam logic [3:0] RW_LB  = 4'b1000;
    localparam logic [3:0] RW_LH  = 4'b1001;
    localparam logic [3:0] RW_LW  = 4'b1010;
    localparam logic [3:0] RW_LBU = 4'b1100;
    localparam logic [3:0] RW_LHU = 4'b1101;
    localparam logic [3:0] RW_SB  = 4'b0001;
    localparam logic [3:0] RW_SH  = 4'b0010;
    localparam logic [3:0] RW_SW  = 4'b0011;

    typedef enum logic [1:0] {IDLE, REQ, DONE} mem_state_t;
    typedef enum logic [1:0] {BYTE, HALF, WORD} mem_size_t;

    typedef struct packed {
        logic      valid;
        logic      we;
        logic      uns;
        mem_size_t size;
    } mem_op_t;

    function automatic mem_op_t decode(input logic [3:0] code);
        case (code)
            RW_LB:   return '{1'b1, 1'b0, 1'b0, BYTE};
            RW_LH:   return '{1'b1, 1'b0, 1'b0, HALF};
            RW_LW:   return '{1'b1, 1'b0, 1'b0, WORD};
            RW_LBU:  return '{1'b1, 1'b0, 1'b1, BYTE};
            RW_LHU:  return '{1'b1, 1'b0, 1'b1, HALF};
            RW_SB:   return '{1'b1, 1'b1, 1'b0, BYTE};
            RW_SH:   return '{1'b1, 1'b1, 1'b0, HALF};
            RW_SW:   return '{1'b1, 1'b1, 1'b0, WORD};
            default: return '{1'b0, 1'b0, 1'b0, BYTE};
        endcase
    endfunction

    function automatic logic [BE_W-1:0] lanes(input mem_size_t size, input logic [1:0] off);
        return size == WORD ? 4'b1111 : size == HALF ? (off[1] ? 4'b1100 : 4'b0011) : 4'b0001 << off;
    endfunction

    function automatic logic [XLEN-1:0] lane_data(input mem_size_t size, input logic [XLEN-1:0] d);
        return size == WORD ? d : size == HALF ? {2{d[15:0]}} : {4{d[7:0]}};
    endfunction

endpackage

// File: rtl/load_align.sv
// load_align: selects the addressed byte/halfword of a read word and sign- or zero-extends it.
module load_align
    import mem_pkg::*;
(
    input  logic [XLEN-1:0] rdata,
    input  logic [1:0]      off,
    input  mem_size_t       size,
    input  logic            uns,
    output logic [XLEN-1:0] data
);

    logic [7:0]  b;
    logic [15:0] h;

    always_comb begin
        b    = rdata[{off, 3'b000} +: 8];
        h    = off[1] ? rdata[31:16] : rdata[15:0];
        data = size == WORD ? rdata
             : size == HALF ? {{16{h[15] & ~uns}}, h}
             : {{24{b[7] & ~uns}}, b};
    end

endmodule

// File: rtl/mem_access_unit.sv
// mem_access_unit: MEM-stage load/store unit with a single-outstanding req/ack data port.
// Define MEM_MISALIGN_TRAP_EN to fault misaligned accesses instead of forcing them aligned.
module mem_access_unit
    import mem_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 255
)(
    input  logic            clk,
    input  logic            reset,
    input  logic [XLEN-1:0] addr_in,
    input  logic [XLEN-1:0] store_data_in,
    input  logic [3:0]      read_write_in,
    output logic            mem_req,
    output logic            mem_we,
    output logic [XLEN-1:0] mem_addr,
    output logic [XLEN-1:0] mem_wdata,
    output logic [BE_W-1:0] mem_be,
    input  logic            mem_ack,
    input  logic [XLEN-1:0] mem_rdata,
    output logic            busywait,
    output logic [XLEN-1:0] load_data,
    output logic            mem_fault
);

    localparam logic [CNT_W-1:0] TMO = CNT_W'(TIMEOUT_CYCLES);

    mem_state_t      state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic            we_q, we_d;
    logic [XLEN-1:0] addr_q, addr_d;
    logic [XLEN-1:0] wdata_q, wdata_d;
    logic [BE_W-1:0] be_q, be_d;
    mem_size_t       size_q, size_d;
    logic            uns_q, uns_d;
    logic [XLEN-1:0] load_data_q, load_data_d;
    logic            fault_q, fault_d;
    mem_op_t         op;
    logic            misaligned;
    logic [XLEN-1:0] aligned;

    assign op = decode(read_write_in);

`ifdef MEM_MISALIGN_TRAP_EN
    assign misaligned = (op.size == HALF && addr_in[0]) || (op.size == WORD && addr_in[1:0] != 2'b00);
`else
    assign misaligned = 1'b0;
`endif

    load_align u_align (
        .rdata(mem_rdata),
        .off  (addr_q[1:0]),
        .size (size_q),
        .uns  (uns_q),
        .data (aligned)
    );

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        we_d        = we_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        be_d        = be_q;
        size_d      = size_q;
        uns_d       = uns_q;
        load_data_d = load_data_q;
        fault_d     = 1'b0;
        busywait    = 1'b0;
        case (state_q)
            IDLE: if (op.valid) begin
                busywait = 1'b1;
                if (misaligned) begin
                    state_d     = DONE;
                    fault_d     = 1'b1;
                    load_data_d = '0;
                end else begin
                    state_d = REQ;
                    cnt_d   = '0;
                    we_d    = op.we;
                    addr_d  = addr_in;
                    wdata_d = lane_data(op.size, store_data_in);
                    be_d    = lanes(op.size, addr_in[1:0]);
                    size_d  = op.size;
                    uns_d   = op.uns;
                end
            end
            REQ: begin
                busywait = 1'b1;
                if (mem_ack) begin
                    state_d     = DONE;
                    load_data_d = aligned;
                end else begin
                    // ack on the limit cycle takes the branch above, so it wins over the abort
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_d == TMO) begin
                        state_d     = DONE;
                        fault_d     = 1'b1;
                        load_data_d = '0;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            we_q        <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            be_q        <= '0;
            size_q      <= BYTE;
            uns_q       <= 1'b0;
            load_data_q <= '0;
            fault_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            we_q        <= we_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            be_q        <= be_d;
            size_q      <= size_d;
            uns_q       <= uns_d;
            load_data_q <= load_data_d;
            fault_q     <= fault_d;
        end
    end

    assign mem_req   = state_q == REQ;
    assign mem_we    = we_q;
    assign mem_addr  = {addr_q[XLEN-1:2], 2'b00};
    assign mem_wdata = wdata_q;
    assign mem_be    = be_q;
    assign load_data = load_data_q;
    assign mem_fault = fault_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// tb_mem_access_unit: randomized accesses checked every cycle against a transaction-level model,
// plus directed literal checks; honours MEM_MISALIGN_TRAP_EN.
module tb_mem_access_unit;

    localparam int TMO = 4;
`ifdef MEM_MISALIGN_TRAP_EN
    localparam bit TRAP = 1'b1;
`else
    localparam bit TRAP = 1'b0;
`endif
    localparam logic [3:0] LB = 4'b1000, LH = 4'b1001, LW = 4'b1010, LBU = 4'b1100, LHU = 4'b1101;
    localparam logic [3:0] SB = 4'b0001, SH = 4'b0010, SW = 4'b0011;

    logic        clk = 1'b0, reset = 1'b1;
    logic [31:0] addr_in = '0, store_data_in = '0, mem_rdata = '0;
    logic [3:0]  read_write_in = '0;
    logic        mem_ack = 1'b0;
    logic        mem_req, mem_we, busywait, mem_fault;
    logic [31:0] mem_addr, mem_wdata, load_data;
    logic [3:0]  mem_be;

    int checks = 0, failures = 0;
    bit chk_en = 1'b0, ld_known = 1'b1;
    logic        exp_busy = 1'b0, exp_req = 1'b0, exp_we = 1'b0, exp_fault = 1'b0;
    logic [31:0] exp_ld = '0, exp_addr = '0, exp_wdata = '0;
    logic [3:0]  exp_be = '0;
    int          busy_cnt = 0, req_cnt = 0, fault_cnt = 0;
    logic [31:0] obs_ld = '0, obs_addr = '0, obs_wdata = '0;
    logic [3:0]  obs_be = '0;
    logic        obs_we = 1'b0;
    logic [3:0]  tbl [8] = '{LB, LH, LW, LBU, LHU, SB, SH, SW};

    mem_access_unit #(.TIMEOUT_CYCLES(TMO)) dut (
        .clk(clk), .reset(reset), .addr_in(addr_in), .store_data_in(store_data_in),
        .read_write_in(read_write_in), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_be(mem_be), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
        .busywait(busywait), .load_data(load_data), .mem_fault(mem_fault)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic void decode(input logic [3:0] c, output int sz, output bit ld, output bit uns);
        sz = 0; ld = 1'b0; uns = 1'b0;
        case (c)
            LB:  begin sz = 1; ld = 1'b1; end
            LH:  begin sz = 2; ld = 1'b1; end
            LW:  begin sz = 4; ld = 1'b1; end
            LBU: begin sz = 1; ld = 1'b1; uns = 1'b1; end
            LHU: begin sz = 2; ld = 1'b1; uns = 1'b1; end
            SB:  sz = 1;
            SH:  sz = 2;
            SW:  sz = 4;
            default: ;
        endcase
    endfunction

    function automatic logic [31:0] extract(input logic [31:0] w, input logic [1:0] off, input int sz, input bit uns);
        logic [31:0] v, m;
        int sh;
        if (sz == 4) return w;
        m  = sz == 1 ? 32'h0000_00FF : 32'h0000_FFFF;
        sh = sz == 1 ? 8 * int'(off) : 16 * int'(off[1]);
        v  = (w >> sh) & m;
        if (!uns && (v & ((m >> 1) + 32'd1)) != 0) v = v | ~m;
        return v;
    endfunction

    // One access from the IDLE cycle through DONE; sets per-cycle expectations as it goes.
    task automatic access(input logic [3:0] code, input logic [31:0] a, input logic [31:0] d,
                          input logic [31:0] rd, input int dly, input bit noise);
        int sz, n;
        bit ld, uns, mis, tmo;
        logic [1:0] off;
        decode(code, sz, ld, uns);
        off = a[1:0];
        mis = TRAP && ((sz == 2 && off[0]) || (sz == 4 && off != 2'b00));
        tmo = sz != 0 && !mis && dly >= TMO;
        busy_cnt = 0; req_cnt = 0; fault_cnt = 0;
        read_write_in = code; addr_in = a; store_data_in = d;
        mem_ack = noise && $urandom_range(0, 1) == 1; mem_rdata = $urandom;
        exp_busy = sz != 0; exp_req = 1'b0; exp_fault = 1'b0;
        step();
        if (sz == 0) return;
        n = mis ? 0 : tmo ? TMO : dly + 1;
        for (int k = 0; k < n; k++) begin
            exp_req = 1'b1; exp_busy = 1'b1; exp_we = !ld; exp_addr = a & ~32'h3;
            exp_be = sz == 4 ? 4'hF : sz == 2 ? (off[1] ? 4'hC : 4'h3) : 4'h1 << off;
            exp_wdata = sz == 4 ? d : sz == 2 ? d[15:0] * 32'h0001_0001 : d[7:0] * 32'h0101_0101;
            mem_ack = k == dly; mem_rdata = k == dly ? rd : $urandom;
            step();
        end
        exp_req = 1'b0; exp_busy = 1'b0; exp_fault = mis || tmo;
        mem_ack = noise && $urandom_range(0, 1) == 1; mem_rdata = $urandom;
        if (mis || tmo) begin exp_ld = '0; ld_known = 1'b1; end
        else if (ld) begin exp_ld = extract(rd, off, sz, uns); ld_known = 1'b1; end
        else ld_known = 1'b0;
        step();
        exp_fault = 1'b0; read_write_in = '0; mem_ack = 1'b0;
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            chk("busywait", 32'(busywait), 32'(exp_busy));
            chk("mem_req", 32'(mem_req), 32'(exp_req));
            chk("mem_fault", 32'(mem_fault), 32'(exp_fault));
            if (ld_known) chk("load_data", load_data, exp_ld);
            if (exp_req) begin
                chk("mem_we", 32'(mem_we), 32'(exp_we));
                chk("mem_addr", mem_addr, exp_addr);
                chk("mem_be", 32'(mem_be), 32'(exp_be));
                if (exp_we) chk("mem_wdata", mem_wdata, exp_wdata);
            end
        end
        busy_cnt += int'(busywait); req_cnt += int'(mem_req); fault_cnt += int'(mem_fault);
        obs_ld = load_data;
        if (mem_req) begin obs_addr = mem_addr; obs_be = mem_be; obs_wdata = mem_wdata; obs_we = mem_we; end
    end

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_req"}, 32'(mem_req), 32'd0);
        chk({tag, "_we"}, 32'(mem_we), 32'd0);
        chk({tag, "_addr"}, mem_addr, 32'd0);
        chk({tag, "_wdata"}, mem_wdata, 32'd0);
        chk({tag, "_be"}, 32'(mem_be), 32'd0);
        chk({tag, "_ld"}, load_data, 32'd0);
        chk({tag, "_fault"}, 32'(mem_fault), 32'd0);
        chk({tag, "_busy"}, 32'(busywait), 32'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        #8;
        chk_reset_vals("por");
        step();
        reset = 1'b0; chk_en = 1'b1;
        access(LW, 32'h0000_1004, 32'h0, 32'hDEAD_BEEF, 0, 1'b0);
        chk("lw_ld", obs_ld, 32'hDEAD_BEEF);
        chk("lw_addr", obs_addr, 32'h0000_1004);
        chk("lw_be", 32'(obs_be), 32'hF);
        chk("lw_busy_cycles", busy_cnt, 2);
        access(LB, 32'h0000_1003, 32'h0, 32'h80FF_0011, 1, 1'b1);
        chk("lb_ld", obs_ld, 32'hFFFF_FF80);
        access(LBU, 32'h0000_1003, 32'h0, 32'h80FF_0011, 0, 1'b1);
        chk("lbu_ld", obs_ld, 32'h0000_0080);
        access(SH, 32'h0000_2002, 32'h1234_ABCD, 32'h0, 0, 1'b0);
        chk("sh_we", 32'(obs_we), 32'd1);
        chk("sh_be", 32'(obs_be), 32'hC);
        chk("sh_wdata", obs_wdata, 32'hABCD_ABCD);
        access(SB, 32'h0000_2001, 32'h1234_ABCD, 32'h0, 2, 1'b1);
        chk("sb_be", 32'(obs_be), 32'h2);
        chk("sb_wdata", obs_wdata, 32'hCDCD_CDCD);
        access(LW, 32'h0000_3000, 32'h0, 32'h5555_5555, 9, 1'b0);
        chk("tmo_req_cycles", req_cnt, TMO);
        chk("tmo_fault_pulses", fault_cnt, 1);
        chk("tmo_ld", obs_ld, 32'h0);
        access(LH, 32'h0000_3002, 32'h0, 32'h8001_0000, TMO - 1, 1'b0);
        chk("ackwins_fault", fault_cnt, 0);
        chk("ackwins_ld", obs_ld, 32'hFFFF_8001);
        access(LW, 32'h0000_1002, 32'h0, 32'hCAFE_F00D, 0, 1'b0);
`ifdef MEM_MISALIGN_TRAP_EN
        chk("mis_req_cycles", req_cnt, 0);
        chk("mis_busy_cycles", busy_cnt, 1);
        chk("mis_fault_pulses", fault_cnt, 1);
        chk("mis_ld", obs_ld, 32'h0);
`else
        chk("mis_addr", obs_addr, 32'h0000_1000);
        chk("mis_be", 32'(obs_be), 32'hF);
        chk("mis_ld", obs_ld, 32'hCAFE_F00D);
`endif
        chk_en = 1'b0;
        read_write_in = LW; addr_in = 32'h0000_4000; mem_ack = 1'b0;
        step();
        #2;
        reset = 1'b1; read_write_in = '0;
        #1;
        chk_reset_vals("rst");
        step();
        reset = 1'b0; mem_ack = 1'b1; mem_rdata = 32'h1111_2222;
        @(negedge clk);
        chk("late_ack_req", 32'(mem_req), 32'd0);
        chk("late_ack_busy", 32'(busywait), 32'd0);
        step();
        mem_ack = 1'b0;
        @(negedge clk);
        chk("late_ack_fault", 32'(mem_fault), 32'd0);
        chk("late_ack_ld", load_data, 32'd0);
        step();
        exp_ld = '0; ld_known = 1'b1; exp_busy = 1'b0; exp_req = 1'b0; exp_fault = 1'b0;
        chk_en = 1'b1;
        for (int i = 0; i < 400; i++) begin
            logic [3:0] c;
            c = $urandom_range(0, 3) != 0 ? tbl[$urandom_range(0, 7)] : 4'($urandom);
            access(c, {20'h0, 12'($urandom)}, $urandom, $urandom, $urandom_range(0, TMO + 1), 1'b1);
        end
        step();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
